// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: shared types and helpers for the data SRAM responder
package data_sram_responder_pkg;

    typedef logic [31:0] CpuData;
    typedef logic [3:0]  ByteStrobe;

    // Word address carried through the queue; the responder keeps only the low index bits
    localparam int WORD_ADDRESS_WIDTH = 30;

    typedef struct packed {
        logic                          write;
        logic [WORD_ADDRESS_WIDTH-1:0] index;
        ByteStrobe                     strobe;
        CpuData                        data;
    } RequestEntry;

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} ResponderState;

    // Replace only the byte lanes selected by strobe
    function automatic CpuData merge_bytes(CpuData old_word, CpuData new_word, ByteStrobe strobe);
        CpuData merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strobe[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_queue.sv
// data_sram_responder_queue: synchronous FIFO holding outstanding requests in order
module data_sram_responder_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop) head_ptr <= head_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Entry storage needs no reset; only slots between head and tail are ever read
    always_ff @(posedge clock) begin
        if (push) slots[tail_ptr] <= push_data;
    end

    assign head_data = slots[head_ptr];
    assign full      = count == (PW+1)'(DEPTH);
    assign empty     = count == '0;

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: in-order word memory responder with programmable latency
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10,
    parameter int QUEUE_DEPTH   = 4,
    parameter int LATENCY       = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request_valid,
    input  logic        request_write,
    input  logic [31:0] request_address,
    input  logic [3:0]  request_write_strobe,
    input  logic [31:0] request_write_data,
    output logic        address_ok,
    output logic        data_ok,
    output logic [31:0] read_data
);

    localparam int CW = $clog2(QUEUE_DEPTH);
    localparam int LW = $clog2(LATENCY + 1);
    localparam logic [LW-1:0] LATENCY_START = LW'(LATENCY - 1);

    CpuData                   memory [2**ADDRESS_WIDTH];
    RequestEntry              incoming;
    RequestEntry              head;
    ResponderState            state;
    ResponderState            state_next;
    logic [LW-1:0]            wait_count;
    logic [LW-1:0]            wait_next;
    logic [CW:0]              count;
    logic [ADDRESS_WIDTH-1:0] head_word;
    logic                     ready;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic                     more;
    logic                     unused_bits;

    assign incoming    = '{write: request_write, index: request_address[31:2],
                           strobe: request_write_strobe, data: request_write_data};
    assign address_ok  = ready & ~full;
    assign push        = request_valid & address_ok;
    assign pop         = state == RESPOND;
    assign more        = count > (CW+1)'(1) || push;
    assign head_word   = head.index[ADDRESS_WIDTH-1:0];
    assign unused_bits = ^{request_address[1:0], head.index, empty};

    data_sram_responder_queue #(
        .WIDTH($bits(RequestEntry)),
        .DEPTH(QUEUE_DEPTH)
    ) request_queue (
        .clock(clock),
        .reset(reset),
        .push(push),
        .push_data(incoming),
        .pop(pop),
        .head_data(head),
        .full(full),
        .empty(empty),
        .count(count)
    );

    // Acceptance is held off for the whole reset and opens one edge after release
    always_ff @(posedge clock) begin
        ready <= reset;
    end

    // Head-service state and latency counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            wait_count <= '0;
        end else begin
            state      <= state_next;
            wait_count <= wait_next;
        end
    end

    // Stores land on the edge that closes their RESPOND cycle; a reset edge discards them
    always_ff @(posedge clock) begin
        if (reset && pop && head.write) memory[head_word] <= merge_bytes(memory[head_word], head.data, head.strobe);
    end

    // Count down the latency, then respond for one cycle and move to the next head entry
    always_comb begin
        state_next = state;
        wait_next  = wait_count;
        data_ok    = 1'b0;
        read_data  = '0;
        case (state)
            IDLE: begin
                if (push) begin
                    state_next = WAIT;
                    wait_next  = LATENCY_START;
                end
            end
            WAIT: begin
                wait_next = wait_count - 1'b1;
                if (wait_count == '0) state_next = RESPOND;
            end
            RESPOND: begin
                data_ok    = 1'b1;
                read_data  = head.write ? '0 : memory[head_word];
                wait_next  = LATENCY_START;
                state_next = !more ? IDLE : (LATENCY == 1 ? RESPOND : WAIT);
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
